// File: rtl/tape_tx.sv
// rtl/tape_tx.sv - cassette square-wave transmitter (leader, sync, payload, trailer); TAPE_TX_CHECKSUM_EN adds an XOR checksum byte
module tape_tx #(
    parameter int HALF0          = 8,
    parameter int HALF1          = 16,
    parameter int SYNC_HALF      = 32,
    parameter int LEADER_CYCLES  = 256,
    parameter int TRAILER_CYCLES = 16,
    parameter int CW             = 12
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       motor,
    input  logic       start,
    input  logic [7:0] byte_data,
    input  logic       byte_last,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       ear,
    output logic       busy,
    output logic       done
);

    localparam logic [CW-1:0] H0_M1        = CW'(HALF0 - 1);
    localparam logic [CW-1:0] H1_M1        = CW'(HALF1 - 1);
    localparam logic [CW-1:0] SYNC_M1      = CW'(SYNC_HALF - 1);
    localparam logic [CW-1:0] LEADER_LAST  = CW'(LEADER_CYCLES - 1);
    localparam logic [CW-1:0] TRAILER_LAST = CW'(TRAILER_CYCLES - 1);
    localparam logic [CW-1:0] BIT_LAST     = CW'(7);

    typedef enum logic [2:0] {
        S_IDLE, S_LEADER, S_SYNC, S_FETCH, S_DATA, S_CSUM, S_TRAILER, S_END
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] tick_cnt, tick_n;
    logic [CW-1:0] cyc_cnt, cyc_n;
    logic [7:0]    shreg, shreg_n;
    logic          last_flag, last_n;
    logic          ear_r, ear_n;
    logic          ready_r, ready_n;
    logic [CW-1:0] half_m1;
    logic          tick, wave, half_end, cycle_end;
`ifdef TAPE_TX_CHECKSUM_EN
    logic [7:0]    csum, csum_n;
`endif

    assign tick = ce & motor;

    always_comb begin
        half_m1 = H0_M1;
        case (state)
            S_SYNC:         half_m1 = SYNC_M1;
            S_DATA, S_CSUM: half_m1 = shreg[7] ? H1_M1 : H0_M1;
            default:        half_m1 = H0_M1;
        endcase
    end

    assign wave      = (state == S_LEADER) || (state == S_SYNC) || (state == S_DATA) ||
                       (state == S_CSUM) || (state == S_TRAILER);
    assign half_end  = wave && tick && (tick_cnt == half_m1);
    // The low half closing is the cycle boundary; every state advance hangs off it.
    assign cycle_end = half_end && !ear_r;

    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        cyc_n   = cyc_cnt;
        shreg_n = shreg;
        last_n  = last_flag;
        ear_n   = ear_r;
        ready_n = ready_r;
`ifdef TAPE_TX_CHECKSUM_EN
        csum_n  = csum;
`endif
        if (wave && tick) begin
            tick_n = half_end ? '0 : tick_cnt + 1'b1;
        end
        if (half_end && ear_r) begin
            ear_n = 1'b0;
        end

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_LEADER;
                    ear_n   = 1'b1;
                    tick_n  = '0;
                    cyc_n   = '0;
`ifdef TAPE_TX_CHECKSUM_EN
                    csum_n  = 8'h00;
`endif
                end
            end
            S_LEADER: begin
                if (cycle_end) begin
                    ear_n = 1'b1;
                    if (cyc_cnt == LEADER_LAST) begin
                        state_n = S_SYNC;
                        cyc_n   = '0;
                    end else begin
                        cyc_n = cyc_cnt + 1'b1;
                    end
                end
            end
            S_SYNC: begin
                if (cycle_end) begin
                    state_n = S_FETCH;
                    ready_n = 1'b1;
                end
            end
            S_FETCH: begin
                if (byte_valid && ready_r) begin
                    state_n = S_DATA;
                    shreg_n = byte_data;
                    last_n  = byte_last;
                    ready_n = 1'b0;
                    ear_n   = 1'b1;
                    tick_n  = '0;
                    cyc_n   = '0;
`ifdef TAPE_TX_CHECKSUM_EN
                    csum_n  = csum ^ byte_data;
`endif
                end
            end
            S_DATA: begin
                if (cycle_end) begin
                    shreg_n = {shreg[6:0], 1'b0};
                    if (cyc_cnt == BIT_LAST) begin
                        cyc_n = '0;
                        if (last_flag) begin
                            ear_n = 1'b1;
`ifdef TAPE_TX_CHECKSUM_EN
                            state_n = S_CSUM;
                            shreg_n = csum;
`else
                            state_n = S_TRAILER;
`endif
                        end else begin
                            state_n = S_FETCH;
                            ready_n = 1'b1;
                        end
                    end else begin
                        cyc_n = cyc_cnt + 1'b1;
                        ear_n = 1'b1;
                    end
                end
            end
`ifdef TAPE_TX_CHECKSUM_EN
            S_CSUM: begin
                if (cycle_end) begin
                    shreg_n = {shreg[6:0], 1'b0};
                    ear_n   = 1'b1;
                    if (cyc_cnt == BIT_LAST) begin
                        state_n = S_TRAILER;
                        cyc_n   = '0;
                    end else begin
                        cyc_n = cyc_cnt + 1'b1;
                    end
                end
            end
`endif
            S_TRAILER: begin
                if (cycle_end) begin
                    if (cyc_cnt == TRAILER_LAST) begin
                        state_n = S_END;
                        cyc_n   = '0;
                    end else begin
                        cyc_n = cyc_cnt + 1'b1;
                        ear_n = 1'b1;
                    end
                end
            end
            S_END:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            tick_cnt  <= '0;
            cyc_cnt   <= '0;
            shreg     <= 8'h00;
            last_flag <= 1'b0;
            ear_r     <= 1'b0;
            ready_r   <= 1'b0;
`ifdef TAPE_TX_CHECKSUM_EN
            csum      <= 8'h00;
`endif
        end else begin
            state     <= state_n;
            tick_cnt  <= tick_n;
            cyc_cnt   <= cyc_n;
            shreg     <= shreg_n;
            last_flag <= last_n;
            ear_r     <= ear_n;
            ready_r   <= ready_n;
`ifdef TAPE_TX_CHECKSUM_EN
            csum      <= csum_n;
`endif
        end
    end

    assign ear        = ear_r;
    assign byte_ready = ready_r;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_END);

endmodule

// File: tb/tb_tape_tx.sv
// tb/tb_tape_tx.sv - randomized scoreboard bench for tape_tx measuring ear half-periods in counted ticks
module tb_tape_tx;

    localparam int H0 = 2;
    localparam int H1 = 4;
    localparam int SH = 6;
    localparam int LC = 3;
    localparam int TC = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ce = 1'b1;
    logic       motor = 1'b1;
    logic       start = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       byte_last = 1'b0;
    logic       byte_valid = 1'b0;
    logic       byte_ready, ear, busy, done;

    always #5 clock = ~clock;

    tape_tx #(
        .HALF0(H0), .HALF1(H1), .SYNC_HALF(SH),
        .LEADER_CYCLES(LC), .TRAILER_CYCLES(TC), .CW(12)
    ) dut (
        .clock(clock), .reset(reset), .ce(ce), .motor(motor), .start(start),
        .byte_data(byte_data), .byte_last(byte_last), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .ear(ear), .busy(busy), .done(done)
    );

    typedef struct packed {
        logic        lvl;
        logic [15:0] len;
    } seg_t;

    seg_t       exp_q[$];
    logic [7:0] fb[$];
    int         n_checks = 0;
    int         n_pass = 0;
    int         done_cnt = 0;
    bit         ce_rand = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    endtask

    task automatic push_seg(input logic lvl, input int len);
        exp_q.push_back({lvl, 16'(len)});
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int k = 7; k >= 0; k--) begin
            int h;
            h = b[k] ? H1 : H0;
            push_seg(1'b1, h);
            push_seg(1'b0, h);
        end
    endtask

    // Expected waveform for the bytes in fb, as (level, counted-tick length) pairs.
    task automatic model_frame();
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < LC; i++) begin push_seg(1'b1, H0); push_seg(1'b0, H0); end
        push_seg(1'b1, SH);
        push_seg(1'b0, SH);
        foreach (fb[i]) begin
            x = x ^ fb[i];
            push_byte(fb[i]);
        end
`ifdef TAPE_TX_CHECKSUM_EN
        push_byte(x);
`endif
        for (int i = 0; i < TC; i++) begin push_seg(1'b1, H0); push_seg(1'b0, H0); end
    endtask

    // Monitor: measures each ear level in counted ticks and pops the scoreboard.
    initial begin
        logic prev_ear, busy_prev, ready_prev, tick_prev, rst_prev, done_prev;
        int   cnt;
        seg_t s;
        prev_ear = 1'b0; busy_prev = 1'b0; ready_prev = 1'b0;
        tick_prev = 1'b0; rst_prev = 1'b1; done_prev = 1'b0; cnt = 0;
        forever begin
            @(negedge clock);
            if (rst_prev) begin
                cnt = 0;
            end else begin
                if (tick_prev) cnt++;
                if (ear !== prev_ear) begin
                    if (!busy_prev) begin
                        cnt = 0;
                    end else begin
                        check("edge_on_tick", int'(tick_prev || ready_prev), 1);
                        check("edge_expected", int'(exp_q.size() != 0), 1);
                        if (exp_q.size() != 0) begin
                            s = exp_q.pop_front();
                            check("seg_level", int'(prev_ear), int'(s.lvl));
                            check("seg_len", cnt, int'(s.len));
                        end
                        cnt = 0;
                    end
                end
                if (done === 1'b1) begin
                    check("final_expected", int'(exp_q.size() == 1), 1);
                    if (exp_q.size() != 0) begin
                        s = exp_q.pop_front();
                        check("final_level", int'(ear), int'(s.lvl));
                        check("final_len", cnt, int'(s.len));
                    end
                    check("done_busy", int'(busy), 1);
                    done_cnt++;
                end
                if (done_prev) check("after_done_busy_done", int'({busy, done}), 0);
            end
            prev_ear   = ear;
            busy_prev  = busy;
            ready_prev = byte_ready;
            tick_prev  = ce && motor && busy && !byte_ready;
            rst_prev   = reset;
            done_prev  = done;
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            ce = ce_rand ? ($urandom_range(0, 9) < 7) : 1'b1;
        end
    end

    initial begin
        repeat (80000) @(posedge clock);
        $display("FAIL watchdog: got no finish, want finish within cycle budget");
        $fatal(1, "timeout");
    end

    task automatic tick_clk();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!byte_ready && n < 3000) begin tick_clk(); n++; end
        check("ready_wait", int'(byte_ready), 1);
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 5000) begin tick_clk(); n++; end
        check("done_wait", int'(done_cnt >= target), 1);
    endtask

    task automatic run_frame(input int stall_idx, input int stall_len, input int motor_gap);
        int target;
        target = done_cnt + 1;
        model_frame();
        start = 1'b1;
        tick_clk();
        start = 1'b0;
        // A byte offered outside FETCH must be ignored.
        byte_valid = 1'b1; byte_data = 8'hEE; byte_last = 1'b1;
        repeat (4) tick_clk();
        byte_valid = 1'b0; byte_last = 1'b0;
        if (motor_gap > 0) begin
            logic e0;
            e0 = ear;
            motor = 1'b0;
            repeat (motor_gap) begin
                tick_clk();
                check("motor_freeze", int'(ear), int'(e0));
            end
            motor = 1'b1;
        end
        foreach (fb[i]) begin
            wait_ready();
            if (i == stall_idx) begin
                repeat (stall_len) begin
                    check("stall_ear", int'(ear), 0);
                    check("stall_ready", int'(byte_ready), 1);
                    tick_clk();
                end
            end
            byte_data = fb[i]; byte_last = (i == fb.size() - 1); byte_valid = 1'b1;
            tick_clk();
            byte_valid = 1'b0; byte_last = 1'b0; byte_data = 8'($urandom);
            if (i == 0) begin
                tick_clk();
                start = 1'b1;
                tick_clk();
                start = 1'b0;
            end
        end
        wait_done(target);
        repeat (3) tick_clk();
    endtask

    initial begin
        int nb;
        repeat (3) tick_clk();
        reset = 1'b0;
        repeat (100) begin
            check("idle_outputs", int'({ear, busy, byte_ready, done}), 0);
            tick_clk();
        end

        fb = '{8'hA5};
        run_frame(-1, 0, 0);
        fb = '{8'h00, 8'hFF};
        run_frame(1, 20, 0);
        fb = '{8'h3C};
        run_frame(-1, 0, 50);

        fb = '{8'h55, 8'h66};
        model_frame();
        start = 1'b1;
        tick_clk();
        start = 1'b0;
        wait_ready();
        byte_data = 8'h55; byte_last = 1'b0; byte_valid = 1'b1;
        tick_clk();
        byte_valid = 1'b0;
        repeat (10) tick_clk();
        reset = 1'b1;
        start = 1'b1;
        tick_clk();
        check("reset_ear", int'(ear), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_ready", int'(byte_ready), 0);
        check("reset_done", int'(done), 0);
        reset = 1'b0;
        start = 1'b0;
        exp_q.delete();
        tick_clk();
        check("start_under_reset", int'(busy), 0);
        fb = '{8'h77};
        run_frame(-1, 0, 0);

        fb = '{8'h12, 8'h34};
        run_frame(-1, 0, 0);

        ce_rand = 1'b1;
        for (int f = 0; f < 6; f++) begin
            fb.delete();
            nb = $urandom_range(1, 3);
            for (int i = 0; i < nb; i++) fb.push_back(8'($urandom));
            run_frame($urandom_range(0, nb - 1), $urandom_range(0, 12),
                      ($urandom_range(0, 1) == 1) ? $urandom_range(1, 30) : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
